// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory-port scheduler: FSM encoding,
// requester indices and the one-hot to index helper.
package mem_sched_pkg;

    localparam int NUM_REQ = 3;

    // Requester indices into the request / grant vectors
    localparam logic [1:0] REQ_ROM = 2'd0;
    localparam logic [1:0] REQ_RD  = 2'd1;
    localparam logic [1:0] REQ_WR  = 2'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Convert a one-hot winner into the requester index stored as last owner
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        if (oh[REQ_WR]) begin
            return REQ_WR;
        end else if (oh[REQ_RD]) begin
            return REQ_RD;
        end else begin
            return REQ_ROM;
        end
    endfunction

endpackage

// File: rtl/mem_sched_arb.sv
// Three-way round-robin picker: the search starts just after the last owner,
// wraps 0->1->2->0, and ignores any masked requester.
module rr_arb3
    import mem_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] eligible;
    logic [1:0]         ord0;
    logic [1:0]         ord1;
    logic [1:0]         ord2;

    assign eligible = req & ~mask;

    // Derive the search order from the last owner; ptr=3 never occurs
    always_comb begin
        case (ptr)
            REQ_ROM: begin
                ord0 = REQ_RD;
                ord1 = REQ_WR;
                ord2 = REQ_ROM;
            end
            REQ_RD: begin
                ord0 = REQ_WR;
                ord1 = REQ_ROM;
                ord2 = REQ_RD;
            end
            default: begin
                ord0 = REQ_ROM;
                ord1 = REQ_RD;
                ord2 = REQ_WR;
            end
        endcase
    end

    // First eligible requester in search order wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        if (eligible[ord0]) begin
            winner[ord0] = 1'b1;
            valid        = 1'b1;
        end else if (eligible[ord1]) begin
            winner[ord1] = 1'b1;
            valid        = 1'b1;
        end else if (eligible[ord2]) begin
            winner[ord2] = 1'b1;
            valid        = 1'b1;
        end
    end

endmodule

// File: rtl/mem_sched.sv
// Round-robin scheduler for the shared memory port. Each grant lasts ACC_CYC
// cycles; re-arbitration on the last cycle gives back-to-back accesses.
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int ACC_CYC = 2,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rom_rd,
    input  logic ram_rd,
    input  logic ram_wr,
    output logic rom_garant,
    output logic ram_garant_rd,
    output logic ram_garant_wr,
    output logic acc_done,
    output logic pause_READ,
    output logic pause_DECODE,
    output logic pause_WRITE,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [1:0]         ptr_q;
    logic [1:0]         ptr_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] gnt_d;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] arb_mask;
    logic [NUM_REQ-1:0] win;
    logic               win_vld;
    logic               last_cyc;

    assign req_vec  = {ram_wr, ram_rd, rom_rd};
    assign last_cyc = (state_q == ACCESS) && (cnt_q == '0);
    // The current owner never wins its own follow-on slot
    assign arb_mask = (state_q == ACCESS) ? gnt_q : '0;

    rr_arb3 u_arb (
        .req    (req_vec),
        .ptr    (ptr_q),
        .mask   (arb_mask),
        .winner (win),
        .valid  (win_vld)
    );

    // State, counter, last-owner pointer and grant registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= REQ_WR;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next state: arbitrate when idle or on the last access cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ACCESS;
                    gnt_d   = win;
                    cnt_d   = CNT_LOAD;
                    ptr_d   = onehot_to_idx(win);
                end
            end
            ACCESS: begin
                if (!last_cyc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (win_vld) begin
                    gnt_d = win;
                    cnt_d = CNT_LOAD;
                    ptr_d = onehot_to_idx(win);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: grants from registers, pauses follow requests directly
    always_comb begin
        rom_garant    = gnt_q[REQ_ROM];
        ram_garant_rd = gnt_q[REQ_RD];
        ram_garant_wr = gnt_q[REQ_WR];
        acc_done      = last_cyc;
        busy          = |gnt_q;
        pause_READ    = rom_rd & ~gnt_q[REQ_ROM];
        pause_DECODE  = ram_rd & ~gnt_q[REQ_RD];
        pause_WRITE   = ram_wr & ~gnt_q[REQ_WR];
    end

endmodule

// File: doc/mem_sched.md
Name: mem_sched

Overview:
- Round-robin scheduler for the single shared memory port used by the three pipeline stages: ROM fetch (READ_ROM), RAM operand read (DECODE) and RAM result write (WRITE).
- Grants the port to one requester for a fixed ACC_CYC-cycle access and supports back-to-back accesses with no turnaround cycle.
- Drives the per-stage pause signals that stall a requester until it is served.
- Intended as the fairness-guaranteeing replacement for the fixed-priority memory resolver in pipelined_control.

Parameters:
ACC_CYC, 2, access duration in cycles per grant; legal range 1..15.
CNT_W, 4, width of the access-cycle counter; must satisfy 2^CNT_W > ACC_CYC.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
rom_rd  input  1  request from the ROM fetch stage (index 0).
ram_rd  input  1  request from the RAM read stage (index 1).
ram_wr  input  1  request from the RAM write stage (index 2).
rom_garant  output  1  ROM fetch owns the port.
ram_garant_rd  output  1  RAM read owns the port.
ram_garant_wr  output  1  RAM write owns the port.
acc_done  output  1  one-cycle pulse on the last cycle of any access.
pause_READ  output  1  equals rom_rd & ~rom_garant.
pause_DECODE  output  1  equals ram_rd & ~ram_garant_rd.
pause_WRITE  output  1  equals ram_wr & ~ram_garant_wr.
busy  output  1  high while any grant is asserted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - last-owner pointer=2, so the first search starts at index 0.
  - All grants, acc_done and busy are 0.
  - Pause outputs are combinational and follow the request inputs directly.
- Requests are levels. A requester holds its request until it sees acc_done, then must drop it the next cycle.
- State machine has two states:
  - IDLE: when any request is sampled high, the arbiter picks a winner. The winner's grant registers high the next cycle, the counter loads ACC_CYC-1, the pointer updates to the winner, and state goes to ACCESS.
  - ACCESS: exactly one grant is high and the counter decrements each cycle. When counter=0 (the last cycle), acc_done=1.
- Last-cycle rules:
  - On the last cycle the arbiter re-arbitrates with the current owner masked out.
  - If a winner exists, its grant is high on the next cycle (back-to-back) and state stays ACCESS.
  - Otherwise all grants drop and state goes to IDLE.
- Round-robin order: search starts at (pointer+1) mod 3 and wraps 0→1→2→0. The first active request wins.
- Latency: request sampled in IDLE → grant after 1 cycle. Each grant lasts exactly ACC_CYC cycles.
- Request dropped mid-access: the access runs to completion. Grant and acc_done timing are unchanged; no abort.
- New request arriving mid-access: it waits, with its pause high, until the arbitration point on the last cycle.
- ACC_CYC=1: every grant cycle is a last cycle, so acc_done is high on every grant cycle.
- Grants are mutually exclusive by construction. Grant is never high without state=ACCESS.
- Starvation bound: a requester waits at most 2 full accesses after the current one ends.
- Reset mid-access: grants drop immediately (asynchronously). No acc_done is produced for the aborted access.

Decomposition:
- Package mem_sched_pkg holds:
  - state encoding (IDLE, ACCESS);
  - requester index constants (REQ_ROM=0, REQ_RD=1, REQ_WR=2);
  - NUM_REQ=3.
- One combinational sub-module, rr_arb3:
  - inputs: 3-bit request vector, 2-bit pointer, 3-bit mask;
  - outputs: one-hot 3-bit winner and a valid bit.
- All state, the counter and the pointer live in mem_sched.

Test Plan:
- ACC_CYC=2. After reset release, rom_rd=1 at cycle 0 → rom_garant=1 in cycles 1-2, acc_done=1 in cycle 2, busy=0 in cycle 3, pause_READ=1 only in cycle 0.
- ACC_CYC=2. All three requests rise at cycle 0 and each drops the cycle after its acc_done → grants are rom in cycles 1-2, ram_rd in 3-4, ram_wr in 5-6. pause_WRITE is high in cycles 0-4. Never two grants high together.
- ACC_CYC=2. rom_rd and ram_rd re-request immediately after each done → grants alternate rom, rd, rom, rd in consecutive cycles with no gaps. ram_wr raised at cycle 3 is granted no later than cycle 7.
- ACC_CYC=3. ram_wr=1 at cycle 0 and dropped at cycle 2 → ram_garant_wr still high for cycles 1-3, acc_done in cycle 3.
- ACC_CYC=3. reset pulled low in cycle 2 of a ram_rd access → ram_garant_rd=0 immediately and no acc_done. After release with ram_rd still high → new grant one cycle later, lasting 3 cycles, starting from pointer=2.
- ACC_CYC=1. Continuous rom_rd and ram_wr → grants alternate every cycle and acc_done stays constantly 1 while busy.
